ip_rx_parser: RTL and testbench
===============================

// Module: ip_rx_parser
// PURPOSE
//  IPv4 receive parser between the MAC rx byte stream and the upper-layer (UDP/ICMP/...) receivers.
//  Parses variable-length headers (IHL 5..15), verifies header checksum, filters on destination IP.
//  Dispatches payload to one of P_NUM_CH protocol channels, trims Ethernet padding, counts dropped datagrams.
// PARAMETERS
//  P_LOCAL_IP     {8'd192,8'd168,8'd1,8'd0}  reset value of local IP used for destination match
//  P_NUM_CH       2                          number of protocol channels (1..8)
//  P_PROTO_LIST   {8'd17,8'd1}               packed protocol numbers; channel i = P_PROTO_LIST[8*i+:8] (ch0 ICMP, ch1 UDP)
//  P_CHK_EN       1                          1: drop datagrams with a bad header checksum; 0: skip the check
//  P_BCAST_EN     1                          1: also accept destination 255.255.255.255
// PORTS
//  i_clk          in   1          clock
//  i_rst_n        in   1          asynchronous active-low reset
//  i_local_ip     in   32         new local IP
//  i_local_valid  in   1          load i_local_ip into local-IP register
//  i_mac_data     in   8          IP datagram byte from MAC rx (Ethernet header already stripped)
//  i_mac_last     in   1          last byte of Ethernet payload
//  i_mac_valid    in   1          byte qualifier; may deassert mid-frame
//  o_data         out  8          payload byte, shared by all channels
//  o_len          out  16         payload length = total_len - 4*IHL, stable from first payload byte to o_last
//  o_src_ip       out  32         source IP of the current datagram
//  o_valid        out  P_NUM_CH   one-hot payload-byte qualifier per channel
//  o_last         out  1          last payload byte (qualified by |o_valid)
//  o_drop         out  1          one-cycle pulse when a datagram is rejected
//  o_drop_cause   out  3          cause code, valid with o_drop
//  o_drop_cnt     out  16         saturating count of rejected datagrams
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; local IP = P_LOCAL_IP; header, checksum and length registers 0.
//  Header bytes are counted only on i_mac_valid cycles; i_mac_valid gaps stall parsing and produce no output.
//  States: IDLE -> HDR on first valid byte. HDR -> PAY after byte 4*IHL-1 if accepted, else DROP.
//   PAY -> IDLE on the byte where i_mac_last=1, or after o_len payload bytes if i_mac_last is not set there (then DROP).
//   DROP -> IDLE on the byte where i_mac_last=1.
//  Header fields:
//   byte0 = version/IHL; bytes 2-3 = total_len; byte 9 = protocol; bytes 12-15 = src; bytes 16-19 = dst.
//   Option bytes (20..4*IHL-1) are consumed and ignored.
//  Checksum: 16-bit ones-complement sum over all 2*IHL header words with end-around carry; must fold to 16'hFFFF.
//  Accept if all hold, in this priority (cause code when violated):
//   1 version==4 && IHL>=5
//   2 total_len >= 4*IHL
//   3 checksum ok (when P_CHK_EN)
//   4 dst == local IP, or P_BCAST_EN && dst == 32'hFFFFFFFF
//   5 protocol is in P_PROTO_LIST; on duplicates the lowest channel wins
//   6 truncation: i_mac_last arrives while in HDR
//  Drop reporting: o_drop pulses 1 cycle after the deciding byte; o_drop_cnt increments in the same cycle, saturates at 16'hFFFF.
//  Local IP: the register value at the final header byte is used for the match; i_local_valid mid-frame affects next frames.
//  Latency: payload byte accepted at cycle t appears on o_data/o_valid at t+2; o_len/o_src_ip valid from the first o_valid.
//  o_last: set on payload byte number o_len (padding that follows is discarded), or earlier on i_mac_last.
//   Early i_mac_last also pulses o_drop with cause 7 (short payload); that datagram is not counted in o_drop_cnt.
//  Zero-length payload (total_len == 4*IHL): no o_valid; frame remainder is discarded; no drop.
//  Reset mid-frame clears everything; the bytes that follow are parsed as a new header and normally dropped.
// STRUCTURE
//  Package ip_rx_pkg: state enum (IDLE/HDR/PAY/DROP), 3-bit drop cause constants (1..7), IPV4_VER=4, IHL_MIN=5, BCAST_IP.
//  Sub-module ip_hdr_csum: byte-in ones-complement accumulator with clear/valid/byte-parity inputs and ok output.
//  Parser FSM, field capture, channel lookup and output pipeline stay in ip_rx_parser.
// TESTING
//  1 UDP, IHL=5, total_len=28, dst=192.168.1.0, valid csum
//    -> o_valid=2'b10 for 8 bytes, o_len=8, o_last on byte 8, o_data at t+2.
//  2 ICMP, IHL=7 (8 option bytes), total_len=40
//    -> o_valid=2'b01, o_len=12, option bytes not forwarded.
//  3 UDP, total_len=30, 16 bytes of Ethernet padding after payload
//    -> exactly 10 payload bytes, o_last on the 10th, padding absent.
//  4 One header byte corrupted
//    -> o_drop=1, o_drop_cause=3, o_drop_cnt+1, no o_valid. Repeat with P_CHK_EN=0 -> accepted.
//  5 Drops: dst=10.0.0.1 -> cause 4; protocol 6 -> cause 5; dst=255.255.255.255 -> accepted.
//    i_local_valid loads 10.0.0.1 -> next frame to 10.0.0.1 accepted.
//  6 i_mac_valid toggling 1/0 through a UDP frame, plus i_rst_n low mid-payload
//    -> gaps preserved, data order intact; reset returns all outputs to 0.
//    Next good frame accepted.

Source files
------------

// File: rtl/ip_rx_pkg.sv
// Shared types and constants for the IPv4 receive parser.
package ip_rx_pkg;

    typedef enum logic [1:0] {IDLE, HDR, PAY, DROP} state_t;

    localparam logic [2:0] CAUSE_VER   = 3'd1;
    localparam logic [2:0] CAUSE_LEN   = 3'd2;
    localparam logic [2:0] CAUSE_CSUM  = 3'd3;
    localparam logic [2:0] CAUSE_DST   = 3'd4;
    localparam logic [2:0] CAUSE_PROTO = 3'd5;
    localparam logic [2:0] CAUSE_TRUNC = 3'd6;
    localparam logic [2:0] CAUSE_SHORT = 3'd7;

    localparam logic [3:0]  IPV4_VER = 4'd4;
    localparam logic [3:0]  IHL_MIN  = 4'd5;
    localparam logic [31:0] BCAST_IP = 32'hFFFF_FFFF;

endpackage

// File: rtl/ip_hdr_csum.sv
// Byte-serial ones-complement header checksum; ok reflects the sum including the current byte.
module ip_hdr_csum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       valid,
    input  logic       odd,
    input  logic [7:0] data,
    output logic       ok
);

    logic [15:0] sum, base, sum_nxt;
    logic [16:0] raw;

    always_comb begin
        base    = clr ? 16'h0 : sum;
        raw     = {1'b0, base} + (odd ? {9'h0, data} : {1'b0, data, 8'h00});
        // end-around carry cannot overflow again: a carry leaves raw[15:0] <= 16'hFFFE
        sum_nxt = raw[15:0] + {15'h0, raw[16]};
        ok      = (sum_nxt == 16'hFFFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     sum <= 16'h0;
        else if (valid) sum <= sum_nxt;
    end

endmodule

// File: rtl/ip_rx_parser.sv
// IPv4 receive parser: header parse/check, destination filter, protocol dispatch, padding trim.
module ip_rx_parser
    import ip_rx_pkg::*;
#(
    parameter logic [31:0]           P_LOCAL_IP   = {8'd192, 8'd168, 8'd1, 8'd0},
    parameter int                    P_NUM_CH     = 2,
    parameter logic [8*P_NUM_CH-1:0] P_PROTO_LIST = {8'd17, 8'd1},
    parameter bit                    P_CHK_EN     = 1'b1,
    parameter bit                    P_BCAST_EN   = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [31:0]         i_local_ip,
    input  logic                i_local_valid,
    input  logic [7:0]          i_mac_data,
    input  logic                i_mac_last,
    input  logic                i_mac_valid,
    output logic [7:0]          o_data,
    output logic [15:0]         o_len,
    output logic [31:0]         o_src_ip,
    output logic [P_NUM_CH-1:0] o_valid,
    output logic                o_last,
    output logic                o_drop,
    output logic [2:0]          o_drop_cause,
    output logic [15:0]         o_drop_cnt
);

    state_t                state;
    logic [5:0]            hcnt, hdr_last;
    logic [3:0]            ver, ihl;
    logic [15:0]           tot_len, pcnt, hdr_bytes, pay_len;
    logic [7:0]            proto;
    logic [31:0]           src, dst, dst_cur, local_ip;
    logic [P_NUM_CH-1:0]   ch_sel, ch_oh, s1_vld;
    logic [7:0]            s1_data;
    logic                  s1_last, ch_hit, csum_ok, hdr_end, pay_fire, pay_end;
    logic                  drop_now;
    logic [2:0]            cause, drop_code;

    ip_hdr_csum u_csum (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .clr  (state == IDLE),
        .valid(i_mac_valid && (state == IDLE || state == HDR)),
        .odd  (hcnt[0]),
        .data (i_mac_data),
        .ok   (csum_ok)
    );

    always_comb begin
        hdr_end   = (state == HDR) && (hcnt == hdr_last);
        hdr_bytes = {10'h0, ihl, 2'b00};
        pay_len   = tot_len - hdr_bytes;
        // with IHL=5 the last dst byte is still on the bus at the deciding byte
        dst_cur   = (hcnt == 6'd19) ? {dst[23:0], i_mac_data} : dst;
        pay_fire  = i_mac_valid && (state == PAY);
        pay_end   = (pcnt + 16'd1 == o_len);
        ch_hit    = 1'b0;
        ch_oh     = '0;
        for (int i = P_NUM_CH - 1; i >= 0; i--) begin
            if (P_PROTO_LIST[8*i +: 8] == proto) begin
                ch_hit    = 1'b1;
                ch_oh     = '0;
                ch_oh[i]  = 1'b1;
            end
        end
        if (ver != IPV4_VER || ihl < IHL_MIN)                          cause = CAUSE_VER;
        else if (tot_len < hdr_bytes)                                  cause = CAUSE_LEN;
        else if (P_CHK_EN && !csum_ok)                                 cause = CAUSE_CSUM;
        else if (!(dst_cur == local_ip || (P_BCAST_EN && dst_cur == BCAST_IP))) cause = CAUSE_DST;
        else if (!ch_hit)                                              cause = CAUSE_PROTO;
        else if (i_mac_last && pay_len != 16'h0)                       cause = CAUSE_TRUNC;
        else                                                           cause = 3'd0;
        drop_now  = 1'b0;
        drop_code = 3'd0;
        if (i_mac_valid) begin
            case (state)
                IDLE: if (i_mac_last) begin drop_now = 1'b1; drop_code = CAUSE_TRUNC; end
                HDR:  if (hdr_end) begin
                          drop_now  = (cause != 3'd0);
                          drop_code = cause;
                      end else if (i_mac_last) begin
                          drop_now  = 1'b1;
                          drop_code = CAUSE_TRUNC;
                      end
                PAY:  if (i_mac_last && !pay_end) begin drop_now = 1'b1; drop_code = CAUSE_SHORT; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;   hcnt <= '0;   hdr_last <= '0;  ver <= '0;  ihl <= '0;
            tot_len <= '0;   pcnt <= '0;   proto <= '0;     src <= '0;  dst <= '0;
            local_ip <= P_LOCAL_IP;        ch_sel <= '0;    o_len <= '0; o_src_ip <= '0;
            o_drop <= 1'b0;  o_drop_cause <= '0;            o_drop_cnt <= '0;
        end else begin
            if (i_local_valid) local_ip <= i_local_ip;
            o_drop       <= drop_now;
            o_drop_cause <= drop_now ? drop_code : 3'd0;
            // short payloads were already accepted, so they are reported but not counted
            if (drop_now && drop_code != CAUSE_SHORT && o_drop_cnt != 16'hFFFF)
                o_drop_cnt <= o_drop_cnt + 16'd1;
            if (i_mac_valid) begin
                case (state)
                    IDLE: begin
                        ver      <= i_mac_data[7:4];
                        ihl      <= i_mac_data[3:0];
                        hdr_last <= (i_mac_data[3:0] < IHL_MIN) ? 6'd19
                                                                : {i_mac_data[3:0], 2'b00} - 6'd1;
                        hcnt     <= i_mac_last ? 6'd0 : 6'd1;
                        state    <= i_mac_last ? IDLE : HDR;
                    end
                    HDR: begin
                        hcnt <= hcnt + 6'd1;
                        case (hcnt)
                            6'd2:                      tot_len[15:8] <= i_mac_data;
                            6'd3:                      tot_len[7:0]  <= i_mac_data;
                            6'd9:                      proto         <= i_mac_data;
                            6'd12, 6'd13, 6'd14, 6'd15: src          <= {src[23:0], i_mac_data};
                            6'd16, 6'd17, 6'd18, 6'd19: dst          <= {dst[23:0], i_mac_data};
                            default: ;
                        endcase
                        if (hdr_end || i_mac_last) begin
                            hcnt <= 6'd0;
                            if (hdr_end && cause == 3'd0) begin
                                o_len    <= pay_len;
                                o_src_ip <= src;
                                ch_sel   <= ch_oh;
                                pcnt     <= 16'h0;
                                // accepted with last set implies zero-length payload
                                state    <= i_mac_last ? IDLE : (pay_len == 16'h0) ? DROP : PAY;
                            end else begin
                                state    <= i_mac_last ? IDLE : DROP;
                            end
                        end
                    end
                    PAY: begin
                        pcnt <= pcnt + 16'd1;
                        if (pay_end || i_mac_last) state <= i_mac_last ? IDLE : DROP;
                    end
                    DROP: if (i_mac_last) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // two-stage payload pipeline
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld <= '0; s1_data <= '0; s1_last <= 1'b0;
            o_valid <= '0; o_data <= '0; o_last <= 1'b0;
        end else begin
            s1_vld  <= pay_fire ? ch_sel : '0;
            s1_last <= pay_fire && (pay_end || i_mac_last);
            if (pay_fire) s1_data <= i_mac_data;
            o_valid <= s1_vld;
            o_data  <= s1_data;
            o_last  <= s1_last;
        end
    end

endmodule

// File: tb/tb_ip_rx_parser.sv
// Directed self-checking bench for ip_rx_parser; a second instance runs with the checksum check off.
module tb_ip_rx_parser;

    localparam logic [31:0] LOCAL = 32'hC0A8_0100;
    localparam logic [31:0] SRC   = 32'hC0A8_0105;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] local_ip;
    logic        local_valid;
    logic [7:0]  mac_data;
    logic        mac_last, mac_valid;
    logic [7:0]  o_data, b_data;
    logic [15:0] o_len, b_len, o_drop_cnt, b_cnt_o;
    logic [31:0] o_src_ip, b_src;
    logic [1:0]  o_valid, b_valid;
    logic        o_last, b_last, o_drop, b_drop;
    logic [2:0]  o_drop_cause, b_cause;

    int nchk = 0, nerr = 0, cyc = 0, b_cnt = 0, exp_cnt = 0;
    logic [7:0]  tx[$];
    int          tx_cyc[$];
    logic [7:0]  rx_data[$];
    logic [1:0]  rx_vld[$];
    logic        rx_last[$];
    logic [15:0] rx_len[$];
    int          rx_cyc[$];
    logic [2:0]  dq_cause[$];
    int          dq_cyc[$];

    ip_rx_parser dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_local_ip(local_ip), .i_local_valid(local_valid),
        .i_mac_data(mac_data), .i_mac_last(mac_last), .i_mac_valid(mac_valid),
        .o_data(o_data), .o_len(o_len), .o_src_ip(o_src_ip), .o_valid(o_valid), .o_last(o_last),
        .o_drop(o_drop), .o_drop_cause(o_drop_cause), .o_drop_cnt(o_drop_cnt)
    );

    ip_rx_parser #(.P_CHK_EN(1'b0)) dut_nochk (
        .i_clk(clk), .i_rst_n(rst_n), .i_local_ip(local_ip), .i_local_valid(local_valid),
        .i_mac_data(mac_data), .i_mac_last(mac_last), .i_mac_valid(mac_valid),
        .o_data(b_data), .o_len(b_len), .o_src_ip(b_src), .o_valid(b_valid), .o_last(b_last),
        .o_drop(b_drop), .o_drop_cause(b_cause), .o_drop_cnt(b_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (|o_valid) begin
            rx_data.push_back(o_data); rx_vld.push_back(o_valid); rx_last.push_back(o_last);
            rx_len.push_back(o_len);   rx_cyc.push_back(cyc);
        end
        if (o_drop) begin dq_cause.push_back(o_drop_cause); dq_cyc.push_back(cyc); end
        if (|b_valid) b_cnt++;
    end

    task automatic build(input int ihl, input int tl, input logic [7:0] proto,
                         input logic [31:0] dst, input int npay, input int npad, input bit corrupt);
        logic [31:0] s;
        logic [15:0] c;
        tx.delete();
        tx.push_back({4'h4, 4'(ihl)}); tx.push_back(8'h00);
        tx.push_back(8'(tl >> 8));     tx.push_back(8'(tl));
        repeat (4) tx.push_back(8'h00);
        tx.push_back(8'd64); tx.push_back(proto); tx.push_back(8'h00); tx.push_back(8'h00);
        for (int j = 3; j >= 0; j--) tx.push_back(SRC[8*j +: 8]);
        for (int j = 3; j >= 0; j--) tx.push_back(dst[8*j +: 8]);
        for (int j = 0; j < 4*ihl - 20; j++) tx.push_back(8'(8'hA0 + j));
        s = 32'h0;
        for (int j = 0; j < 2*ihl; j++) s = s + {16'h0, tx[2*j], tx[2*j+1]};
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        c = ~s[15:0];
        tx[10] = c[15:8]; tx[11] = c[7:0];
        if (corrupt) tx[8] = tx[8] ^ 8'h01;
        for (int j = 0; j < npay; j++) tx.push_back(8'(8'h10 + j));
        for (int j = 0; j < npad; j++) tx.push_back(8'hEE);
    endtask

    task automatic clear_rx();
        rx_data.delete(); rx_vld.delete(); rx_last.delete(); rx_len.delete(); rx_cyc.delete();
        dq_cause.delete(); dq_cyc.delete(); tx_cyc.delete(); b_cnt = 0;
    endtask

    // drives the first n bytes of tx; last is flagged only on the real final byte
    task automatic send(input bit gaps, input int n);
        for (int i = 0; i < n; i++) begin
            mac_data = tx[i]; mac_valid = 1'b1; mac_last = (i == tx.size() - 1);
            tx_cyc.push_back(cyc);
            @(posedge clk); #1;
            if (gaps) begin mac_valid = 1'b0; mac_last = 1'b0; @(posedge clk); #1; end
        end
        mac_valid = 1'b0; mac_last = 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nchk++; if (o_valid !== 2'b00) begin nerr++; $display("FAIL reset_valid: got %0h want 0", o_valid); end
        nchk++; if (o_data !== 8'h00) begin nerr++; $display("FAIL reset_data: got %0h want 0", o_data); end
        nchk++; if (o_drop !== 1'b0 || o_last !== 1'b0) begin nerr++; $display("FAIL reset_flags: got drop=%0b last=%0b want 0", o_drop, o_last); end
        nchk++; if (o_drop_cnt !== 16'h0) begin nerr++; $display("FAIL reset_cnt: got %0h want 0", o_drop_cnt); end
        nchk++; if (o_len !== 16'h0 || o_src_ip !== 32'h0) begin nerr++; $display("FAIL reset_len_src: got %0h %0h want 0", o_len, o_src_ip); end
    endtask

    task automatic test_udp_basic();
        clear_rx(); build(5, 28, 8'd17, LOCAL, 8, 0, 1'b0); send(1'b0, tx.size()); settle();
        nchk++; if (rx_data.size() !== 8) begin nerr++; $display("FAIL udp_count: got %0d want 8", rx_data.size()); end
        for (int i = 0; i < rx_data.size(); i++) begin
            nchk++;
            if (rx_data[i] !== 8'(8'h10 + i) || rx_vld[i] !== 2'b10 || rx_last[i] !== (i == 7)) begin
                nerr++; $display("FAIL udp_byte%0d: got d=%0h v=%0b l=%0b want d=%0h v=10 l=%0b",
                                 i, rx_data[i], rx_vld[i], rx_last[i], 8'(8'h10 + i), i == 7);
            end
        end
        nchk++; if (rx_len.size() == 0 || rx_len[0] !== 16'd8) begin nerr++; $display("FAIL udp_len: got %0d want 8", rx_len.size() ? rx_len[0] : 16'hFFFF); end
        nchk++; if (rx_cyc.size() < 8 || rx_cyc[7] - tx_cyc[27] !== 2) begin nerr++; $display("FAIL udp_latency: got %0d want 2", rx_cyc.size() >= 8 ? rx_cyc[7] - tx_cyc[27] : -1); end
        nchk++; if (o_src_ip !== SRC) begin nerr++; $display("FAIL udp_src: got %0h want %0h", o_src_ip, SRC); end
        nchk++; if (dq_cause.size() !== 0) begin nerr++; $display("FAIL udp_nodrop: got %0d drops want 0", dq_cause.size()); end
    endtask

    task automatic test_icmp_options();
        clear_rx(); build(7, 40, 8'd1, LOCAL, 12, 0, 1'b0); send(1'b0, tx.size()); settle();
        nchk++; if (rx_data.size() !== 12) begin nerr++; $display("FAIL icmp_count: got %0d want 12", rx_data.size()); end
        for (int i = 0; i < rx_data.size(); i++) begin
            nchk++;
            if (rx_data[i] !== 8'(8'h10 + i) || rx_vld[i] !== 2'b01 || rx_len[i] !== 16'd12) begin
                nerr++; $display("FAIL icmp_byte%0d: got d=%0h v=%0b len=%0d want d=%0h v=01 len=12",
                                 i, rx_data[i], rx_vld[i], rx_len[i], 8'(8'h10 + i));
            end
        end
    endtask

    task automatic test_padding();
        clear_rx(); build(5, 30, 8'd17, LOCAL, 10, 16, 1'b0); send(1'b0, tx.size()); settle();
        nchk++; if (rx_data.size() !== 10) begin nerr++; $display("FAIL pad_count: got %0d want 10", rx_data.size()); end
        nchk++; if (rx_data.size() < 10 || rx_last[9] !== 1'b1 || rx_data[9] !== 8'h19) begin nerr++; $display("FAIL pad_last: byte10 last/data wrong, count %0d want 10", rx_data.size()); end
        nchk++; if (dq_cause.size() !== 0) begin nerr++; $display("FAIL pad_nodrop: got %0d drops want 0", dq_cause.size()); end
    endtask

    task automatic test_edges();
        // zero-length payload: silently discarded
        clear_rx(); build(5, 20, 8'd17, LOCAL, 0, 6, 1'b0); send(1'b0, tx.size()); settle();
        nchk++; if (rx_data.size() !== 0 || dq_cause.size() !== 0) begin nerr++; $display("FAIL zero_len: got %0d bytes %0d drops want 0 0", rx_data.size(), dq_cause.size()); end
        // short payload: last early, cause 7, not counted
        clear_rx(); build(5, 28, 8'd17, LOCAL, 5, 0, 1'b0); send(1'b0, tx.size()); settle();
        nchk++; if (rx_data.size() !== 5 || rx_last[rx_data.size()-1] !== 1'b1) begin nerr++; $display("FAIL short_bytes: got %0d want 5 with last", rx_data.size()); end
        nchk++; if (dq_cause.size() !== 1 || dq_cause[0] !== 3'd7) begin nerr++; $display("FAIL short_cause: got n=%0d want one cause 7", dq_cause.size()); end
        nchk++; if (o_drop_cnt !== 16'(exp_cnt)) begin nerr++; $display("FAIL short_cnt: got %0d want %0d", o_drop_cnt, exp_cnt); end
        // truncated header: cause 6
        clear_rx(); build(5, 28, 8'd17, LOCAL, 8, 0, 1'b0); tx = tx[0:9]; send(1'b0, tx.size()); settle();
        exp_cnt++;
        nchk++; if (dq_cause.size() !== 1 || dq_cause[0] !== 3'd6) begin nerr++; $display("FAIL trunc_cause: got n=%0d want one cause 6", dq_cause.size()); end
        nchk++; if (o_drop_cnt !== 16'(exp_cnt)) begin nerr++; $display("FAIL trunc_cnt: got %0d want %0d", o_drop_cnt, exp_cnt); end
    endtask

    task automatic test_bad_csum();
        clear_rx(); build(5, 28, 8'd17, LOCAL, 8, 0, 1'b1); send(1'b0, tx.size()); settle();
        exp_cnt++;
        nchk++; if (dq_cause.size() !== 1 || dq_cause[0] !== 3'd3) begin nerr++; $display("FAIL csum_cause: got n=%0d want one cause 3", dq_cause.size()); end
        nchk++; if (dq_cyc.size() == 0 || dq_cyc[0] - tx_cyc[19] !== 1) begin nerr++; $display("FAIL csum_timing: drop not 1 cycle after byte 19 (n=%0d)", dq_cyc.size()); end
        nchk++; if (o_drop_cnt !== 16'(exp_cnt)) begin nerr++; $display("FAIL csum_cnt: got %0d want %0d", o_drop_cnt, exp_cnt); end
        nchk++; if (rx_data.size() !== 0) begin nerr++; $display("FAIL csum_noval: got %0d bytes want 0", rx_data.size()); end
        nchk++; if (b_cnt !== 8) begin nerr++; $display("FAIL csum_off_accept: got %0d bytes want 8", b_cnt); end
    endtask

    task automatic test_filters();
        clear_rx(); build(5, 28, 8'd17, 32'h0A00_0001, 8, 0, 1'b0); send(1'b0, tx.size()); settle();
        exp_cnt++;
        nchk++; if (dq_cause.size() !== 1 || dq_cause[0] !== 3'd4) begin nerr++; $display("FAIL dst_cause: got n=%0d want one cause 4", dq_cause.size()); end
        clear_rx(); build(5, 28, 8'd6, LOCAL, 8, 0, 1'b0); send(1'b0, tx.size()); settle();
        exp_cnt++;
        nchk++; if (dq_cause.size() !== 1 || dq_cause[0] !== 3'd5) begin nerr++; $display("FAIL proto_cause: got n=%0d want one cause 5", dq_cause.size()); end
        nchk++; if (o_drop_cnt !== 16'(exp_cnt)) begin nerr++; $display("FAIL filter_cnt: got %0d want %0d", o_drop_cnt, exp_cnt); end
        clear_rx(); build(5, 28, 8'd17, 32'hFFFF_FFFF, 8, 0, 1'b0); send(1'b0, tx.size()); settle();
        nchk++; if (rx_data.size() !== 8 || dq_cause.size() !== 0) begin nerr++; $display("FAIL bcast: got %0d bytes %0d drops want 8 0", rx_data.size(), dq_cause.size()); end
        local_ip = 32'h0A00_0001; local_valid = 1'b1; @(posedge clk); #1; local_valid = 1'b0;
        clear_rx(); build(5, 28, 8'd1, 32'h0A00_0001, 8, 0, 1'b0); send(1'b0, tx.size()); settle();
        nchk++; if (rx_data.size() !== 8 || rx_vld[0] !== 2'b01) begin nerr++; $display("FAIL new_local: got %0d bytes want 8 on ch0", rx_data.size()); end
    endtask

    task automatic test_gaps_reset();
        clear_rx(); build(5, 28, 8'd17, 32'h0A00_0001, 8, 0, 1'b0); send(1'b1, tx.size()); settle(); settle();
        nchk++; if (rx_data.size() !== 8) begin nerr++; $display("FAIL gap_count: got %0d want 8", rx_data.size()); end
        for (int i = 1; i < rx_data.size(); i++) begin
            nchk++;
            if (rx_data[i] !== 8'(8'h10 + i) || rx_cyc[i] - rx_cyc[i-1] !== 2) begin
                nerr++; $display("FAIL gap_byte%0d: got d=%0h spacing %0d want d=%0h spacing 2",
                                 i, rx_data[i], rx_cyc[i] - rx_cyc[i-1], 8'(8'h10 + i));
            end
        end
        clear_rx(); build(5, 28, 8'd17, 32'h0A00_0001, 8, 0, 1'b0); send(1'b0, 23);
        rst_n = 1'b0; #1;
        exp_cnt = 0;
        nchk++; if (o_valid !== 2'b00 || o_data !== 8'h00 || o_last !== 1'b0 || o_drop !== 1'b0) begin nerr++; $display("FAIL midrst_out: got v=%0b d=%0h want 0", o_valid, o_data); end
        nchk++; if (o_drop_cnt !== 16'h0 || o_len !== 16'h0 || o_src_ip !== 32'h0) begin nerr++; $display("FAIL midrst_regs: got cnt=%0d len=%0d src=%0h want 0", o_drop_cnt, o_len, o_src_ip); end
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1; @(posedge clk); #1;
        clear_rx(); build(5, 28, 8'd17, LOCAL, 8, 0, 1'b0); send(1'b0, tx.size()); settle();
        nchk++; if (rx_data.size() !== 8 || dq_cause.size() !== 0) begin nerr++; $display("FAIL post_rst: got %0d bytes %0d drops want 8 0", rx_data.size(), dq_cause.size()); end
    endtask

    initial begin
        rst_n = 1'b0; local_ip = 32'h0; local_valid = 1'b0;
        mac_data = 8'h0; mac_last = 1'b0; mac_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1; @(posedge clk); #1;
        test_udp_basic();
        test_icmp_options();
        test_padding();
        test_edges();
        test_bad_csum();
        test_filters();
        test_gaps_reset();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
